// File: rtl/branch_predict_unit_pkg.sv
// Shared MIPS constants for branch resolution and prediction: branch codes,
// 2-bit counter states and the saturating counter step.
package branch_predict_unit_pkg;

    typedef enum logic [2:0] {
        BRANCH_OFF  = 3'd0,
        BRANCH_BEQ  = 3'd1,
        BRANCH_BNE  = 3'd2,
        BRANCH_BLEZ = 3'd3,
        BRANCH_BGTZ = 3'd4,
        BRANCH_BLTZ = 3'd5,
        BRANCH_BGEZ = 3'd6
    } branch_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Code 7 is reserved and, like OFF, never counts as a resolve event.
    function automatic logic is_resolve_code(input logic [2:0] code);
        return (code >= BRANCH_BEQ) && (code <= BRANCH_BGEZ);
    endfunction

    function automatic logic [1:0] counter_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken && (cur != ST))
            nxt = cur + 2'd1;
        else if (!taken && (cur != SNT))
            nxt = cur - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Execute-stage resolve bus between the EX pipeline register and the branch unit.
interface branch_predict_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    // No ready: the unit accepts every cycle; validInput qualifies one instruction
    // per cycle and upstream drops it while EX is stalled. Results follow one edge later.
    logic                  validInput;
    logic [2:0]            branchInput;
    logic [DATA_WIDTH-1:0] rsInput;
    logic [DATA_WIDTH-1:0] rtInput;
    logic [PC_WIDTH-1:0]   pcInput;
    logic [PC_WIDTH-1:0]   targetInput;
    logic                  predictedTakenInput;
    logic                  branchTakenOutput;
    logic                  mispredictOutput;
    logic [PC_WIDTH-1:0]   redirectPcOutput;

    modport master (
        output validInput, branchInput, rsInput, rtInput, pcInput, targetInput,
               predictedTakenInput,
        input  branchTakenOutput, mispredictOutput, redirectPcOutput
    );

    modport slave (
        input  validInput, branchInput, rsInput, rtInput, pcInput, targetInput,
               predictedTakenInput,
        output branchTakenOutput, mispredictOutput, redirectPcOutput
    );
endinterface

// File: rtl/branch_predict_unit_branch_condition.sv
// Combinational MIPS branch condition evaluation on full-width operands.
module branch_condition
    import branch_predict_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            branch,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic                  taken
);
    logic rs_neg;
    logic rs_zero;

    always_comb begin
        rs_neg  = rs[DATA_WIDTH-1];
        rs_zero = (rs == '0);
        taken   = 1'b0;
        // Sign tests look only at rs; rt matters for the equality pair alone.
        case (branch)
            BRANCH_BEQ:  taken = (rs == rt);
            BRANCH_BNE:  taken = (rs != rt);
            BRANCH_BLEZ: taken = rs_neg || rs_zero;
            BRANCH_BGTZ: taken = !rs_neg && !rs_zero;
            BRANCH_BLTZ: taken = rs_neg;
            BRANCH_BGEZ: taken = !rs_neg;
            default:     taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a 2-bit counter table read by Fetch,
// registered mispredict redirect and saturating branch statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         DATA_WIDTH   = 32,
    parameter int         PC_WIDTH     = 32,
    parameter int         BHT_ENTRIES  = 16,
    parameter logic [1:0] COUNTER_INIT = 2'b01,
    parameter int         COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    fetchPcInput,
    output logic                   predictTakenOutput,
    branch_predict_unit_if.slave   ex,
    output logic [COUNT_WIDTH-1:0] branchCountOutput,
    output logic [COUNT_WIDTH-1:0] mispredictCountOutput
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [1:0]             bht [BHT_ENTRIES];
    logic [IDX-1:0]         fetch_idx;
    logic [IDX-1:0]         ex_idx;
    logic                   event_valid;
    logic                   cond_taken;
    logic                   mispredict;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   taken_q;
    logic                   mispredict_q;
    logic [PC_WIDTH-1:0]    redirect_q;
    logic [COUNT_WIDTH-1:0] branch_count;
    logic [COUNT_WIDTH-1:0] mispredict_count;
    logic                   unused_fetch_bits;

    branch_condition #(.DATA_WIDTH(DATA_WIDTH)) u_cond (
        .branch (ex.branchInput),
        .rs     (ex.rsInput),
        .rt     (ex.rtInput),
        .taken  (cond_taken)
    );

    assign fetch_idx         = fetchPcInput[IDX+1:2];
    assign ex_idx            = ex.pcInput[IDX+1:2];
    assign unused_fetch_bits = ^{fetchPcInput[PC_WIDTH-1:IDX+2], fetchPcInput[1:0]};

    // Reads the table directly, so a same-cycle update to this entry is not seen yet.
    assign predictTakenOutput = bht[fetch_idx][1];

    always_comb begin
        event_valid = ex.validInput && is_resolve_code(ex.branchInput);
        mispredict  = event_valid && (cond_taken != ex.predictedTakenInput);
        next_pc     = cond_taken ? ex.targetInput : ex.pcInput + PC_WIDTH'(4);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= COUNTER_INIT;
        end else if (event_valid) begin
            bht[ex_idx] <= counter_next(bht[ex_idx], cond_taken);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            taken_q          <= 1'b0;
            mispredict_q     <= 1'b0;
            redirect_q       <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            taken_q      <= event_valid && cond_taken;
            mispredict_q <= mispredict;
            redirect_q   <= mispredict ? next_pc : '0;
            if (event_valid && (branch_count != '1))
                branch_count <= branch_count + COUNT_WIDTH'(1);
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + COUNT_WIDTH'(1);
        end
    end

    assign ex.branchTakenOutput  = taken_q;
    assign ex.mispredictOutput   = mispredict_q;
    assign ex.redirectPcOutput   = redirect_q;
    assign branchCountOutput     = branch_count;
    assign mispredictCountOutput = mispredict_count;
endmodule
